// File: rtl/comptador_descendent.sv
// comptador_descendent -- loadable down-counter / interval timer.
//
// A start value is loaded with a load strobe; the counter then decrements on
// every cycle with en high and raises a one-cycle terminal-count pulse on the
// edge where out reaches 0. Dropping en while running pauses the count.
//
// Optional build macro: COMPTADOR_AUTO_RELOAD_EN
//   undefined : one-shot, terminal count parks the block in DONE.
//   defined   : periodic, the next enabled edge after terminal count restores
//               out from the reload register (period reload+1 cycles).
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   en        count enable
//   load      load strobe (beats en)
//   load_val  start / reload value
//   out       current count (registered)
//   busy      high while in RUN (registered)
//   tc        terminal-count pulse, one cycle (registered)
//
// state | meaning
// IDLE  | nothing loaded (or 0 loaded); en ignored
// ARMED | nonzero value loaded, or paused; waiting for en
// RUN   | counting down on every enabled edge
// DONE  | one-shot finished; out held at 0 until load

module comptador_descendent #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic [WIDTH-1:0] out_next;
  logic             tc_next;

  // One enabled counting step, shared by ARMED (first step of a run) and RUN.
  // Handles the terminal count and, with auto-reload, the restart from 0.
  task automatic count_step(output state_t    st,
                            output logic [WIDTH-1:0] val,
                            output logic      t);
    st  = RUN;
    val = out;
    t   = 1'b0;
    if (out > WIDTH'(1)) begin
      val = out - WIDTH'(1);
    end else if (out == WIDTH'(1)) begin
      val = '0;
      t   = 1'b1;
`ifdef COMPTADOR_AUTO_RELOAD_EN
      st  = RUN;
`else
      st  = DONE;
`endif
    end else begin
      // out == 0: only reachable after a terminal count
`ifdef COMPTADOR_AUTO_RELOAD_EN
      val = reload;
      st  = RUN;
`else
      st  = DONE;
`endif
    end
  endtask

  always_comb begin
    state_next  = state;
    out_next    = out;
    reload_next = reload;
    tc_next     = 1'b0;

    if (load) begin
      out_next    = load_val;
      reload_next = load_val;
      state_next  = (load_val == '0) ? IDLE : ARMED;
    end else begin
      case (state)
        IDLE: begin
        end
        ARMED: begin
          if (en) begin
            count_step(state_next, out_next, tc_next);
          end
        end
        RUN: begin
          if (en) begin
            count_step(state_next, out_next, tc_next);
          end else begin
            state_next = ARMED;
          end
        end
        DONE: begin
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_next;
      out    <= out_next;
      reload <= reload_next;
      tc     <= tc_next;
      busy   <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_comptador_descendent.sv
module tb_comptador_descendent;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] out;
  logic       busy;
  logic       tc;

  int n_checks = 0;
  int n_pass   = 0;

  comptador_descendent #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .busy     (busy),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance one rising edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    en       = 1'b0;
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    int first_tc;
    int tc_count;
    logic [7:0] exp_out;
    logic       exp_tc;

    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_tc", tc, 0);

    // en without load: stays idle
    en = 1'b1;
    tick(); tick();
    check("noload_out", out, 0);
    check("noload_busy", busy, 0);

    // asynchronous reset mid-cycle while running
    do_load(8'd7);
    check("ld7_out", out, 7);
    en = 1'b1;
    tick();
    check("run7_out", out, 6);
    check("run7_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_out", out, 0);
    check("async_busy", busy, 0);
    check("async_tc", tc, 0);
    tick();
    rst = 1'b0;
    en  = 1'b0;

    // one-shot from 5
    do_load(8'd5);
    check("os_load", out, 5);
    check("os_load_busy", busy, 0);
    en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("os_out", out, 32'(i));
      check("os_tc", tc, (i == 0) ? 1 : 0);
`ifndef COMPTADOR_AUTO_RELOAD_EN
      check("os_busy", busy, (i == 0) ? 0 : 1);
`endif
    end
    tick();
`ifdef COMPTADOR_AUTO_RELOAD_EN
    check("os_reload", out, 5);
    check("os_reload_tc", tc, 0);
`else
    check("os_after_out", out, 0);
    check("os_after_tc", tc, 0);
    check("os_after_busy", busy, 0);
    tick();
    check("os_after2_out", out, 0);
`endif

    // pause
    do_load(8'd10);
    en = 1'b1;
    tick(); tick(); tick();
    check("pause_pre", out, 7);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pause_out", out, 7);
      check("pause_busy", busy, 0);
    end
    en = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      tick();
      check("resume_out", out, 32'(i));
      check("resume_tc", tc, (i == 0) ? 1 : 0);
    end

    // load beats a would-be terminal count
    do_load(8'd3);
    en = 1'b1;
    tick(); tick();
    check("prio_pre", out, 1);
    load = 1'b1; load_val = 8'd9;
    tick();
    load = 1'b0;
    check("prio_out", out, 9);
    check("prio_tc", tc, 0);
    check("prio_busy", busy, 0);
    en = 1'b0;
    tick();
    check("prio_hold", out, 9);
    en = 1'b1;
    tick();
    check("prio_armed_dec", out, 8);
    check("prio_armed_busy", busy, 1);

    // zero load -> IDLE
    do_load(8'd0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_out", out, 0);
      check("zero_tc", tc, 0);
      check("zero_busy", busy, 0);
    end

    // max load 255
    do_load(8'd255);
    check("max_load", out, 255);
    en = 1'b1;
    first_tc = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (tc) begin
        first_tc = n;
        break;
      end
    end
    check("max_tc_edge", 32'(first_tc), 255);
    check("max_out", out, 0);
    tick();
`ifdef COMPTADOR_AUTO_RELOAD_EN
    check("max_reload", out, 255);
`else
    check("max_nowrap", out, 0);
`endif
    check("max_tc_low", tc, 0);

    // periodic vs one-shot with reload 3
    do_load(8'd3);
    en = 1'b1;
    tc_count = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef COMPTADOR_AUTO_RELOAD_EN
      exp_out = 8'(3 - (k % 4));
      exp_tc  = ((k % 4) == 3);
`else
      exp_out = (k < 3) ? 8'(3 - k) : 8'd0;
      exp_tc  = (k == 3);
`endif
      if (tc) tc_count++;
      check("rl_out", out, 32'(exp_out));
      check("rl_tc", tc, 32'(exp_tc));
    end
`ifdef COMPTADOR_AUTO_RELOAD_EN
    check("rl_tc_count", 32'(tc_count), 3);
`else
    check("rl_tc_count", 32'(tc_count), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
